// File: rtl/lcd_text_formatter.sv
// lcd_text_formatter
//   Upstream feeder for the 16x2 LCD controller. Owns the two 128-bit line
//   buffers that the controller scans and updates them from a single command
//   port: write one character, render a hex number as ASCII, or clear both
//   lines. Exactly one character is written per clock.
//
// Ports
//   clk_50mhz     system clock
//   rst           asynchronous active-low reset (0 = reset)
//   cmd_valid     command request
//   cmd_ready     high only while idle; command accepted on valid & ready
//   cmd_op        00 char, 01 hex, 10 clear, 11 reserved (accepted, no-op)
//   cmd_row       0 = line1, 1 = line2
//   cmd_col       start column, 0 = leftmost
//   cmd_char      ASCII byte for the char op
//   cmd_value     value rendered by the hex op
//   cmd_digits    hex digit count; 0 or >8 means 8
//   done          one-cycle pulse when a command completes
//   line1_buffer  line 1, column c at bits [127-8c -: 8]
//   line2_buffer  line 2, same mapping
module lcd_text_formatter #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic         clk_50mhz,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic         cmd_row,
  input  logic [3:0]   cmd_col,
  input  logic [7:0]   cmd_char,
  input  logic [31:0]  cmd_value,
  input  logic [3:0]   cmd_digits,
  output logic         done,
  output logic [127:0] line1_buffer,
  output logic [127:0] line2_buffer
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEX   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [1:0] OP_CHAR  = 2'b00;
  localparam logic [1:0] OP_HEX   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) begin
      c = 8'h30 + {4'h0, n};
    end else begin
      c = 8'h41 + ({4'h0, n} - 8'd10);
    end
    return c;
  endfunction

  // Effective digit count: 0 and anything above 8 render all 8 nibbles.
  function automatic logic [3:0] eff_digits(input logic [3:0] d);
    logic [3:0] n;
    if ((d == 4'd0) || (d > 4'd8)) begin
      n = 4'd8;
    end else begin
      n = d;
    end
    return n;
  endfunction

  state_t         state;
  state_t         state_next;
  logic           done_next;
  logic           accept;

  // Latched hex command. The value is left-aligned at acceptance so the
  // next digit to render is always the top nibble.
  logic           hex_row;
  logic [4:0]     hex_col;   // 5 bits so stepping past column 15 is seen as 16
  logic [3:0]     hex_cnt;
  logic [3:0]     hex_ndig;
  logic [31:0]    hex_shift;
  logic [4:0]     clr_idx;   // {row, col} of the next clear write
  logic [3:0]     load_ndig;

  // Single buffer write port.
  logic           wr_en;
  logic           wr_row;
  logic [3:0]     wr_col;
  logic [7:0]     wr_data;
  logic [6:0]     wr_bit;

  logic [127:0]   line1;
  logic [127:0]   line2;

  assign accept       = cmd_valid & cmd_ready;
  assign load_ndig    = eff_digits(cmd_digits);
  assign wr_bit       = 7'd127 - {wr_col, 3'b000};
  assign line1_buffer = line1;
  assign line2_buffer = line2;

  // Next-state, completion and buffer write-port selection.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    wr_en      = 1'b0;
    wr_row     = hex_row;
    wr_col     = hex_col[3:0];
    wr_data    = CLEAR_CHAR;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CHAR: begin
              wr_en     = 1'b1;
              wr_row    = cmd_row;
              wr_col    = cmd_col;
              wr_data   = cmd_char;
              done_next = 1'b1;
            end
            OP_HEX:   state_next = HEX;
            OP_CLEAR: state_next = CLEAR;
            default:  done_next  = 1'b1;
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      HEX: begin
        wr_en   = 1'b1;
        wr_row  = hex_row;
        wr_col  = hex_col[3:0];
        wr_data = hex_ascii(hex_shift[31:28]);
        // Finish on the last requested digit or when the next column would
        // fall off the right edge (no wrap).
        if ((hex_cnt == (hex_ndig - 4'd1)) || ((hex_col + 5'd1) == 5'd16)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = HEX;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_row  = clr_idx[4];
        wr_col  = clr_idx[3:0];
        wr_data = CLEAR_CHAR;
        if (clr_idx == 5'd31) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = CLEAR;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state, ready and done registers.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      done      <= done_next;
    end
  end

  // Hex and clear sequencing registers.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      hex_row   <= 1'b0;
      hex_col   <= 5'd0;
      hex_cnt   <= 4'd0;
      hex_ndig  <= 4'd8;
      hex_shift <= 32'd0;
      clr_idx   <= 5'd0;
    end else begin
      if (accept && (cmd_op == OP_HEX)) begin
        hex_row   <= cmd_row;
        hex_col   <= {1'b0, cmd_col};
        hex_cnt   <= 4'd0;
        hex_ndig  <= load_ndig;
        hex_shift <= cmd_value << {(4'd8 - load_ndig), 2'b00};
      end else if (state == HEX) begin
        hex_col   <= hex_col + 5'd1;
        hex_cnt   <= hex_cnt + 4'd1;
        hex_shift <= {hex_shift[27:0], 4'h0};
      end else begin
        hex_col   <= hex_col;
      end
      if (accept) begin
        clr_idx <= 5'd0;
      end else if (state == CLEAR) begin
        clr_idx <= clr_idx + 5'd1;
      end else begin
        clr_idx <= clr_idx;
      end
    end
  end

  // Line buffers: one character per write, reset fills with CLEAR_CHAR.
  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      line1 <= {16{CLEAR_CHAR}};
      line2 <= {16{CLEAR_CHAR}};
    end else if (wr_en) begin
      if (wr_row) begin
        line2[wr_bit -: 8] <= wr_data;
      end else begin
        line1[wr_bit -: 8] <= wr_data;
      end
    end else begin
      line1 <= line1;
    end
  end

endmodule

// File: doc/lcd_text_formatter.md
Name: lcd_text_formatter

Overview:
- Upstream feeder for the 16x2 LCD controller; owns the two 128-bit line buffers the controller scans.
- Other blocks (status monitors, counters) write single characters, render hex numbers as ASCII, or clear the display through one command port.
- Replaces hard-wired text with run-time content; buffer outputs connect directly to the controller's line1_buffer/line2_buffer inputs.

Parameters:
- CLEAR_CHAR, 8'h20, character written on reset and by the clear command.

Ports:
- clk_50mhz  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-low reset; 0 = reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 = char, 01 = hex, 10 = clear, 11 = reserved; treated as no-op and accepted.
- cmd_row  in  1  0 = line1, 1 = line2.
- cmd_col  in  4  start column, 0 = leftmost.
- cmd_char  in  8  ASCII byte for the char op.
- cmd_value  in  32  value for the hex op.
- cmd_digits  in  4  hex digit count; 0 or values above 8 mean 8.
- done  out  1  one-cycle pulse when a command completes.
- line1_buffer  out  128  line 1; column c occupies bits [127-8c -: 8].
- line2_buffer  out  128  line 2; same mapping.

Behaviour:
- Clock is clk_50mhz. Reset is asynchronous and active-low (rst = 0). Asynchronous assert, synchronous deassert is handled externally.
- Reset values:
  - All 32 characters = CLEAR_CHAR.
  - cmd_ready = 1, done = 0, FSM in IDLE.
- Handshake:
  - A command is accepted at a rising edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready = 1 only in IDLE.
  - All cmd_* inputs are latched at acceptance; later input changes are ignored.
- FSM states: IDLE, HEX, CLEAR. Exactly one buffer character is written per clock.
- char op:
  - Written at the accepting edge E0.
  - done = 1 in the cycle after E0.
  - FSM stays in IDLE; back-to-back char ops run at 1 per cycle.
- hex op:
  - E0 latches the command; FSM moves to HEX.
  - N = effective digit count. Nibbles N-1 down to 0 of cmd_value are rendered, most significant first.
  - Digit k is written at edge E(k+1) to column cmd_col+k.
  - Encoding: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10), uppercase.
  - No wrap: if cmd_col+k > 15, the remaining digits are dropped and the op ends after the last in-range write.
  - done = 1 in the cycle after the final write; FSM returns to IDLE on the same edge as that write.
  - Column counter is 5 bits wide so column 16 is detected, not aliased to 0.
- clear op:
  - Edges E1..E32 write CLEAR_CHAR to line1 cols 0..15, then line2 cols 0..15.
  - cmd_ready is low for exactly 32 cycles; done follows the last write.
- reserved op: accepted, no buffer change, done the cycle after E0.
- Row/column fields are ignored for clear.
- Buffer outputs are registered; a write is visible the cycle after its edge. No other bits change.
- Reset mid-operation: buffers return immediately to CLEAR_CHAR, the operation is abandoned, and no done pulse is issued.
- The downstream controller may sample the buffers at any time. Partial updates (tearing) are acceptable.

Test Plan:
- Release reset -> all 32 characters 0x20, cmd_ready = 1, done = 0.
- char op, row 0, col 2, char 0x48 -> line1_buffer[111:104] = 0x48, single done pulse, cmd_ready never drops; a second char op on the next cycle is also accepted.
- hex op, row 1, col 0, value 0x00C0FFEE, digits 0 -> line2 cols 0-7 = 30 30 43 30 46 46 45 45; cmd_ready low 8 cycles; line1 unchanged.
- hex op, row 0, col 14, value 0xABCD, digits 4 -> col 14 = 0x41, col 15 = 0x42, col 0 untouched; done after 2 writes.
- Fill both lines, then clear op with cmd_valid held and inputs changing during the op -> all characters 0x20 after 32 cycles, exactly one done, no second command accepted before cmd_ready returns.
- Assert rst during the 5th digit of an 8-digit hex op -> buffers immediately 0x20, no done pulse; after deassert cmd_ready = 1 and a new char op completes normally.
